// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the two-pair binary-to-BCD seven-segment scanner.
// Holds the converter FSM encoding, digit widths, range limit and one double-dabble step.
package bin_bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV_A = 2'd1,
      ST_CONV_B = 2'd2,
      ST_LATCH  = 2'd3
   } conv_state_t;

   localparam int BCD_W    = 4;
   localparam int BIN_W    = 7;
   localparam int STEPS    = BIN_W;
   localparam int PAIR_MAX = 99;
   localparam int WORK_W   = 2*BCD_W + BIN_W;

   localparam logic [BIN_W-1:0] PAIR_LIMIT = BIN_W'(PAIR_MAX);
   localparam logic [BCD_W-1:0] BCD_DASH   = 4'hF;
   localparam logic [6:0]       SEG_DASH   = 7'b0111111;

   // Work word is {tens, units, remaining binary}; add-3 on each BCD nibble, then shift left.
   function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
      logic [WORK_W-1:0] adj;
      adj = w;
      if (adj[10:7] >= 4'd5) begin
         adj[10:7] = adj[10:7] + 4'd3;
      end
      if (adj[14:11] >= 4'd5) begin
         adj[14:11] = adj[14:11] + 4'd3;
      end
      return {adj[WORK_W-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment pattern (seg[0]=a .. seg[6]=g).
// Codes 10-15 render as a dash so an out-of-range pair can be flagged by digit code alone.
module bcd_to_seg7
   import bin_bcd_pkg::*;
(
   input  logic [BCD_W-1:0] i_bcd,
   output logic [6:0]       o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = 7'b1000000;
         4'd1:    o_seg = 7'b1111001;
         4'd2:    o_seg = 7'b0100100;
         4'd3:    o_seg = 7'b0110000;
         4'd4:    o_seg = 7'b0011001;
         4'd5:    o_seg = 7'b0010010;
         4'd6:    o_seg = 7'b0000010;
         4'd7:    o_seg = 7'b1111000;
         4'd8:    o_seg = 7'b0000000;
         4'd9:    o_seg = 7'b0010000;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bin_bcd_seg_scan.sv
// Converts two 0..99 binary values to BCD with one shared serial double-dabble engine
// and multiplexes the four resulting digits onto a common-anode seven-segment display.
module bin_bcd_seg_scan
   import bin_bcd_pkg::*;
#(
   parameter int SCAN_DIV = 50000
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [BIN_W-1:0] val_a,
   input  logic [BIN_W-1:0] val_b,
   input  logic             load,
   input  logic             en,
   output logic             busy,
   output logic             done,
   output logic [3:0]       an,
   output logic [6:0]       seg
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   conv_state_t       r_state;
   conv_state_t       w_state_next;
   logic              w_capture;
   logic              w_step_en;
   logic              w_last_step;
   logic              w_latch;

   logic [BIN_W-1:0]  r_bin_a;
   logic [BIN_W-1:0]  r_bin_b;
   logic [WORK_W-1:0] r_work;
   logic [WORK_W-1:0] w_work_step;
   logic [2:0]        r_step;
   logic [7:0]        r_res_a;
   logic [7:0]        r_res_b;
   logic              r_done;

   logic [BCD_W-1:0]  r_digit      [4];
   logic [BCD_W-1:0]  w_digit_next [4];

   logic [PW-1:0]     r_presc;
   logic [1:0]        r_idx;
   logic [1:0]        w_idx_next;
   logic              w_wrap;
   logic [6:0]        w_seg_next;
   logic [3:0]        r_an;
   logic [6:0]        r_seg;

   // ---------------- converter FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_step_en    = 1'b0;
      w_last_step  = 1'b0;
      w_latch      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load) begin
               w_capture    = 1'b1;
               w_state_next = ST_CONV_A;
            end
         end
         ST_CONV_A: begin
            w_step_en   = 1'b1;
            w_last_step = (r_step == 3'(STEPS-1));
            if (w_last_step) begin
               w_state_next = ST_CONV_B;
            end
         end
         ST_CONV_B: begin
            w_step_en   = 1'b1;
            w_last_step = (r_step == 3'(STEPS-1));
            if (w_last_step) begin
               w_state_next = ST_LATCH;
            end
         end
         ST_LATCH: begin
            w_latch      = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign busy = (r_state != ST_IDLE);
   assign done = r_done;

   // ---------------- serial double-dabble datapath ----------------
   assign w_work_step = dabble_step(r_work);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bin_a <= '0;
         r_bin_b <= '0;
         r_work  <= '0;
         r_step  <= '0;
         r_res_a <= '0;
         r_res_b <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_latch;
         if (w_capture) begin
            r_bin_a <= val_a;
            r_bin_b <= val_b;
            r_work  <= {8'd0, val_a};
            r_step  <= '0;
         end else if (w_step_en) begin
            if (w_last_step) begin
               r_step <= '0;
               // Engine is reused: pair A's result is parked and pair B is loaded in the same edge.
               if (r_state == ST_CONV_A) begin
                  r_res_a <= w_work_step[WORK_W-1:BIN_W];
                  r_work  <= {8'd0, r_bin_b};
               end else begin
                  r_res_b <= w_work_step[WORK_W-1:BIN_W];
               end
            end else begin
               r_step <= r_step + 3'd1;
               r_work <= w_work_step;
            end
         end
      end
   end

   always_comb begin
      w_digit_next = r_digit;
      if (w_latch) begin
         if (r_bin_a > PAIR_LIMIT) begin
            w_digit_next[0] = BCD_DASH;
            w_digit_next[1] = BCD_DASH;
         end else begin
            w_digit_next[0] = r_res_a[3:0];
            w_digit_next[1] = r_res_a[7:4];
         end
         if (r_bin_b > PAIR_LIMIT) begin
            w_digit_next[2] = BCD_DASH;
            w_digit_next[3] = BCD_DASH;
         end else begin
            w_digit_next[2] = r_res_b[3:0];
            w_digit_next[3] = r_res_b[7:4];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            r_digit[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            r_digit[i] <= w_digit_next[i];
         end
      end
   end

   // ---------------- display scan ----------------
   assign w_wrap     = (r_presc == PW'(SCAN_DIV-1));
   assign w_idx_next = w_wrap ? (r_idx + 2'd1) : r_idx;

   // Decode from next-state digits so freshly latched values appear on the latch edge.
   bcd_to_seg7 u_seg7 (
      .i_bcd (w_digit_next[w_idx_next]),
      .o_seg (w_seg_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
         r_idx   <= '0;
         r_an    <= 4'b1110;
         r_seg   <= 7'b1000000;
      end else begin
         r_presc <= w_wrap ? '0 : (r_presc + PW'(1));
         r_idx   <= w_idx_next;
         r_an    <= en ? ~(4'b0001 << w_idx_next) : 4'b1111;
         r_seg   <= w_seg_next;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;

endmodule

// File: tb/tb_bin_bcd_seg_scan.sv
// Directed bench for bin_bcd_seg_scan with a short scan period; expected patterns hand-derived.
module tb_bin_bcd_seg_scan;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] val_a;
   logic [6:0] val_b;
   logic       load;
   logic       en;
   logic       busy;
   logic       done;
   logic [3:0] an;
   logic [6:0] seg;

   int vectors    = 0;
   int miscompares = 0;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;

   bin_bcd_seg_scan #(.SCAN_DIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .val_a (val_a),
      .val_b (val_b),
      .load  (load),
      .en    (en),
      .busy  (busy),
      .done  (done),
      .an    (an),
      .seg   (seg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Bounded wait (at falling edges) for a given anode pattern.
   task automatic wait_an(input logic [3:0] target, input string tag);
      int n;
      n = 0;
      while (an !== target && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {12'd0, an}, {12'd0, target});
   endtask

   task automatic check_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] e [4];
      logic [3:0] one;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      one = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         wait_an(~(one << i), {tag, "_an"});
         chk($sformatf("%s_seg%0d", tag, i), {9'd0, seg}, {9'd0, e[i]});
      end
   endtask

   // Called at the falling edge right after the load edge k; follows edges k+1..k+20.
   task automatic watch(input string tag, input int reload_at, input logic [6:0] ra,
                        input logic [6:0] rb, input bit hold_zero);
      int busy_cnt;
      int done_cnt;
      int done_at;
      busy_cnt = busy ? 1 : 0;
      done_cnt = 0;
      done_at  = -1;
      for (int j = 1; j <= 20; j++) begin
         if (j == reload_at) begin
            val_a = ra;
            val_b = rb;
            load  = 1'b1;
         end
         @(negedge clk);
         load = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_at = j;
         end
         if (hold_zero && j < 15) chk({tag, "_hold"}, {9'd0, seg}, {9'd0, S0});
      end
      chk({tag, "_busy_cycles"}, 16'(busy_cnt), 16'd15);
      chk({tag, "_done_at"}, 16'(done_at), 16'd15);
      chk({tag, "_done_count"}, 16'(done_cnt), 16'd1);
      $display("conv %s: busy_cycles=%0d done_at=%0d done_count=%0d", tag, busy_cnt, done_at, done_cnt);
   endtask

   task automatic do_conv(input string tag, input logic [6:0] a, input logic [6:0] b,
                          input int reload_at, input logic [6:0] ra, input logic [6:0] rb);
      @(negedge clk);
      val_a = a;
      val_b = b;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      watch(tag, reload_at, ra, rb, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      val_a = '0;
      val_b = '0;
      load  = 1'b0;
      en    = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_done", {15'd0, done}, 16'd0);
      chk("rst_an",   {12'd0, an},   {12'd0, 4'b1110});
      chk("rst_seg",  {9'd0, seg},   {9'd0, S0});
      reset = 1'b0;

      do_conv("c23_59", 7'd23, 7'd59, 0, 7'd0, 7'd0);
      check_digits("c23_59", S3, S2, S9, S5);

      do_conv("c0_99", 7'd0, 7'd99, 0, 7'd0, 7'd0);
      check_digits("c0_99", S0, S0, S9, S9);

      do_conv("c100_7", 7'd100, 7'd7, 0, 7'd0, 7'd0);
      check_digits("c100_7", SD, SD, S7, S0);

      do_conv("reload", 7'd23, 7'd59, 5, 7'd88, 7'd11);
      check_digits("reload", S3, S2, S9, S5);

      // Align to the edge where the index wraps to 0, then blank the display.
      wait_an(4'b0111, "en_align3");
      wait_an(4'b1110, "en_align0");
      en = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         chk($sformatf("en_off_an%0d", c), {12'd0, an}, {12'd0, 4'b1111});
         chk($sformatf("en_off_seg%0d", c), {9'd0, seg}, {9'd0, (c < 4) ? S3 : S2});
      end
      en = 1'b1;
      @(negedge clk);
      chk("en_on_an",  {12'd0, an},  {12'd0, 4'b1011});
      chk("en_on_seg", {9'd0, seg},  {9'd0, S9});
      $display("en test: anode restored to %04b", an);

      // Reset in the middle of CONV_B, then a load in the first cycle after release.
      @(negedge clk);
      val_a = 7'd35;
      val_b = 7'd62;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_busy", {15'd0, busy}, 16'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_an",   {12'd0, an},   {12'd0, 4'b1110});
      chk("mid_rst_seg",  {9'd0, seg},   {9'd0, S0});
      chk("mid_rst_busy", {15'd0, busy}, 16'd0);
      chk("mid_rst_done", {15'd0, done}, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      val_a = 7'd41;
      val_b = 7'd76;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      watch("post_rst", 0, 7'd0, 7'd0, 1'b1);
      check_digits("post_rst", S1, S4, S6, S7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
